icdir_nway: RTL and testbench

//  Set-associative I-cache tag directory; successor to the direct-mapped single-way directory.
//  Per set: WAYS tag/valid entries plus a tree-PLRU state.

---
 rtl/icdir_nway_pkg.sv | 22 ++
 rtl/icdir_plru.sv | 54 +++++
 rtl/icdir_nway.sv | 191 +++++++++++++++++++
 tb/tb_icdir_nway.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/icdir_nway_pkg.sv
// Purpose: shared FSM encoding and width helpers for the set-associative I-cache tag directory.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package icdir_nway_pkg;

   // Directory sequencer states: normal operation or flash-invalidate sweep
   typedef enum logic {
      ICDIR_IDLE  = 1'b0,
      ICDIR_SWEEP = 1'b1
   } icdir_state_e;

   // Tree-PLRU state bits per set (WAYS-1 nodes; one dummy bit for a single way)
   function automatic int plru_w(input int ways);
      return (ways > 1) ? ways - 1 : 1;
   endfunction

   // Way-number width, never narrower than one bit
   function automatic int way_w(input int ways);
      return (ways > 1) ? $clog2(ways) : 1;
   endfunction

endpackage

// File: rtl/icdir_plru.sv
// Purpose: tree-PLRU decode for one directory set: victim pick and mark-MRU next state.
// Latency: combinational.
// Backpressure: none; pure function of the supplied tree state.
module icdir_plru
   import icdir_nway_pkg::*;
#(
   parameter int WAYS = 4,
   localparam int PW = plru_w(WAYS),
   localparam int WW = way_w(WAYS)
) (
   input  logic [PW-1:0] lk_tree,
   input  logic [WW-1:0] lk_way,
   output logic [PW-1:0] lk_tree_mru,
   output logic [WW-1:0] lk_victim,
   input  logic [PW-1:0] wr_tree,
   input  logic [WW-1:0] wr_way,
   output logic [PW-1:0] wr_tree_mru
);
   // Heap-ordered tree: node 0 is the root, children of n are 2n+1 / 2n+2.
   // A node bit of 0 steers the victim to the lower half, 1 to the upper half.
   localparam int LV = (WAYS > 1) ? $clog2(WAYS) : 0;
   localparam int NW = (PW > 1) ? $clog2(PW) : 1;

   // Walk root to leaf along way w, pointing every node away from it
   function automatic logic [PW-1:0] mark_mru(input logic [PW-1:0] t, input logic [WW-1:0] w);
      logic [PW-1:0] r;
      logic [NW:0]   node;
      r    = t;
      node = '0;
      for (int l = LV - 1; l >= 0; l--) begin
         r[node[NW-1:0]] = ~w[l];
         node = (node << 1) + (NW+1)'(1) + (NW+1)'(w[l]);
      end
      return r;
   endfunction

   // Follow the node bits from the root; each level supplies one victim bit, MSB first
   function automatic logic [WW-1:0] victim_of(input logic [PW-1:0] t);
      logic [WW-1:0] v;
      logic [NW:0]   node;
      v    = '0;
      node = '0;
      for (int l = LV - 1; l >= 0; l--) begin
         v[l] = t[node[NW-1:0]];
         node = (node << 1) + (NW+1)'(1) + (NW+1)'(t[node[NW-1:0]]);
      end
      return v;
   endfunction

   assign lk_tree_mru = mark_mru(lk_tree, lk_way);
   assign lk_victim   = victim_of(lk_tree);
   assign wr_tree_mru = mark_mru(wr_tree, wr_way);

endmodule

// File: rtl/icdir_nway.sv
// Purpose: N-way I-cache tag directory with tree-PLRU, fill/invalidate and flash-invalidate sweep.
// Latency: lookup result registered, valid one cycle after acceptance.
// Backpressure: lk_rdy low (busy) during a sweep; lookups and writes offered then are dropped.
// Optional feature: define ICDIR_PARITY_EN for per-entry even parity over {valid,tag}.
module icdir_nway
   import icdir_nway_pkg::*;
#(
   parameter int SETS  = 64,
   parameter int WAYS  = 4,
   parameter int TAG_W = 22,
   localparam int IDX_W = $clog2(SETS),
   localparam int WAY_W = way_w(WAYS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             lk_val,
   input  logic [IDX_W-1:0] lk_idx,
   input  logic [TAG_W-1:0] lk_tag,
   output logic             lk_rdy,
   output logic             rsp_val,
   output logic             rsp_hit,
   output logic [WAY_W-1:0] rsp_way,
   output logic [WAY_W-1:0] rsp_victim,
   input  logic             wr_en,
   input  logic             wr_inv,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic [WAY_W-1:0] wr_way,
   input  logic [TAG_W-1:0] wr_tag,
   input  logic             inv_all,
   output logic             busy,
   output logic             rsp_perr
);
   localparam int PW = plru_w(WAYS);

   icdir_state_e     state_q;
   logic [IDX_W-1:0] cnt_q;

   // Directory storage; contents become defined once the post-reset sweep has visited each set
   logic [TAG_W-1:0] tag_q  [SETS][WAYS];
   logic [WAYS-1:0]  vld_q  [SETS];
   logic [PW-1:0]    plru_q [SETS];

   logic             lk_acc, wr_ok, hit_upd;
   logic             hit_c, inv_c;
   logic [WAY_W-1:0] hit_way_c, inv_way_c, victim_c, plru_victim;
   logic [PW-1:0]    lk_tree_mru, wr_tree_mru;

`ifdef ICDIR_PARITY_EN
   logic [WAYS-1:0]  par_q [SETS];
   logic             perr_c;
   logic [WAY_W-1:0] perr_way_c;
`endif

   assign busy    = (state_q == ICDIR_SWEEP);
   assign lk_rdy  = ~busy;
   assign lk_acc  = lk_val & lk_rdy;
   // A flash invalidate in the same cycle supersedes any fill or invalidate
   assign wr_ok   = wr_en & ~busy & ~inv_all & ~rst;
   assign hit_upd = lk_acc & hit_c & ~rst;

   icdir_plru #(.WAYS(WAYS)) u_plru (
      .lk_tree     (plru_q[lk_idx]),
      .lk_way      (hit_way_c),
      .lk_tree_mru (lk_tree_mru),
      .lk_victim   (plru_victim),
      .wr_tree     (plru_q[wr_idx]),
      .wr_way      (wr_way),
      .wr_tree_mru (wr_tree_mru)
   );

   // Tag compare over the looked-up set; descending scan leaves the lowest matching/invalid way
   always_comb begin
      hit_c     = 1'b0;
      hit_way_c = '0;
      inv_c     = 1'b0;
      inv_way_c = '0;
`ifdef ICDIR_PARITY_EN
      perr_c     = 1'b0;
      perr_way_c = '0;
`endif
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (vld_q[lk_idx][w] && (tag_q[lk_idx][w] == lk_tag)) begin
            hit_c     = 1'b1;
            hit_way_c = WAY_W'(w);
         end
         if (!vld_q[lk_idx][w]) begin
            inv_c     = 1'b1;
            inv_way_c = WAY_W'(w);
         end
`ifdef ICDIR_PARITY_EN
         if (par_q[lk_idx][w] != ^{vld_q[lk_idx][w], tag_q[lk_idx][w]}) begin
            perr_c     = 1'b1;
            perr_way_c = WAY_W'(w);
         end
`endif
      end
`ifdef ICDIR_PARITY_EN
      // A corrupt entry makes any match untrustworthy: report a miss
      if (perr_c) begin
         hit_c     = 1'b0;
         hit_way_c = '0;
      end
`endif
   end

   // Victim choice: corrupt way first, then lowest invalid way, else the PLRU pick
   always_comb begin
      victim_c = inv_c ? inv_way_c : plru_victim;
`ifdef ICDIR_PARITY_EN
      if (perr_c) victim_c = perr_way_c;
`endif
   end

   // Sweep sequencer and registered lookup response
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ICDIR_SWEEP;
         cnt_q      <= '0;
         rsp_val    <= 1'b0;
         rsp_hit    <= 1'b0;
         rsp_way    <= '0;
         rsp_victim <= '0;
`ifdef ICDIR_PARITY_EN
         rsp_perr   <= 1'b0;
`endif
      end else begin
         rsp_val <= lk_acc;
         if (lk_acc) begin
            rsp_hit    <= hit_c;
            rsp_way    <= hit_way_c;
            rsp_victim <= victim_c;
`ifdef ICDIR_PARITY_EN
            rsp_perr   <= perr_c;
`endif
         end
         case (state_q)
            ICDIR_IDLE: begin
               if (inv_all) begin
                  state_q <= ICDIR_SWEEP;
                  cnt_q   <= '0;
               end
            end
            ICDIR_SWEEP: begin
               if (inv_all) begin
                  cnt_q <= '0;
               end else if (cnt_q == IDX_W'(SETS - 1)) begin
                  state_q <= ICDIR_IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + IDX_W'(1);
               end
            end
         endcase
      end
   end

`ifndef ICDIR_PARITY_EN
   assign rsp_perr = 1'b0;
`endif

   // Storage update: sweep clears one set per cycle; otherwise hit-MRU, then writes (write PLRU wins)
   always_ff @(posedge clk) begin
      if (!rst && (state_q == ICDIR_SWEEP)) begin
         // Tags are zeroed too so stored parity is consistent for every swept entry
         vld_q[cnt_q]  <= '0;
         plru_q[cnt_q] <= '0;
         for (int w = 0; w < WAYS; w++) tag_q[cnt_q][w] <= '0;
`ifdef ICDIR_PARITY_EN
         par_q[cnt_q]  <= '0;
`endif
      end else begin
         if (hit_upd) plru_q[lk_idx] <= lk_tree_mru;
         if (wr_ok) begin
            if (wr_inv) begin
               vld_q[wr_idx][wr_way] <= 1'b0;
`ifdef ICDIR_PARITY_EN
               par_q[wr_idx][wr_way] <= ^{1'b0, tag_q[wr_idx][wr_way]};
`endif
            end else begin
               tag_q[wr_idx][wr_way] <= wr_tag;
               vld_q[wr_idx][wr_way] <= 1'b1;
               plru_q[wr_idx]        <= wr_tree_mru;
`ifdef ICDIR_PARITY_EN
               par_q[wr_idx][wr_way] <= ^{1'b1, wr_tag};
`endif
            end
         end
      end
   end

endmodule

// File: tb/tb_icdir_nway.sv
// Purpose: directed scoreboard bench for icdir_nway (4 ways, 64 sets, 22-bit tags).
// Latency: expects each accepted lookup to respond on the following cycle.
// Backpressure: checks that lookups and writes offered during a sweep are dropped.
module tb_icdir_nway;
   localparam int SETS  = 64;
   localparam int WAYS  = 4;
   localparam int TAG_W = 22;
   localparam int IDX_W = 6;
   localparam int WAY_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             lk_val;
   logic [IDX_W-1:0] lk_idx;
   logic [TAG_W-1:0] lk_tag;
   logic             lk_rdy;
   logic             rsp_val, rsp_hit, rsp_perr, busy;
   logic [WAY_W-1:0] rsp_way, rsp_victim;
   logic             wr_en, wr_inv, inv_all;
   logic [IDX_W-1:0] wr_idx;
   logic [WAY_W-1:0] wr_way;
   logic [TAG_W-1:0] wr_tag;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic             hit;
      logic [WAY_W-1:0] way;
      logic [WAY_W-1:0] vic;
      logic             perr;
      string            name;
   } exp_t;
   exp_t exp_q[$];

   icdir_nway #(.SETS(SETS), .WAYS(WAYS), .TAG_W(TAG_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .lk_val     (lk_val),
      .lk_idx     (lk_idx),
      .lk_tag     (lk_tag),
      .lk_rdy     (lk_rdy),
      .rsp_val    (rsp_val),
      .rsp_hit    (rsp_hit),
      .rsp_way    (rsp_way),
      .rsp_victim (rsp_victim),
      .wr_en      (wr_en),
      .wr_inv     (wr_inv),
      .wr_idx     (wr_idx),
      .wr_way     (wr_way),
      .wr_tag     (wr_tag),
      .inv_all    (inv_all),
      .busy       (busy),
      .rsp_perr   (rsp_perr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_rsp(input string name, input logic hit, input logic [WAY_W-1:0] way,
                             input logic [WAY_W-1:0] vic, input logic perr);
      exp_t e;
      e.hit = hit; e.way = way; e.vic = vic; e.perr = perr; e.name = name;
      exp_q.push_back(e);
   endtask

   // One cycle of stimulus, applied at a falling edge and released at the next one
   task automatic cyc(input logic lv, input logic [IDX_W-1:0] li, input logic [TAG_W-1:0] lt,
                      input logic we, input logic wi, input logic [IDX_W-1:0] wx,
                      input logic [WAY_W-1:0] ww, input logic [TAG_W-1:0] wt, input logic ia);
      lk_val = lv; lk_idx = li; lk_tag = lt;
      wr_en = we; wr_inv = wi; wr_idx = wx; wr_way = ww; wr_tag = wt;
      inv_all = ia;
      @(negedge clk);
      lk_val = 1'b0; wr_en = 1'b0; wr_inv = 1'b0; inv_all = 1'b0;
   endtask

   task automatic look(input logic [IDX_W-1:0] li, input logic [TAG_W-1:0] lt);
      cyc(1'b1, li, lt, 1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   task automatic fill(input logic [IDX_W-1:0] wx, input logic [WAY_W-1:0] ww, input logic [TAG_W-1:0] wt);
      cyc(1'b0, '0, '0, 1'b1, 1'b0, wx, ww, wt, 1'b0);
   endtask

   // Monitor: every presented response is matched against the oldest expectation
   initial begin
      forever begin
         @(negedge clk);
         if (rsp_val === 1'b1) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rsp: got rsp_val=1 expected no response");
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               chk(e.name, {26'd0, rsp_hit, rsp_way, rsp_victim, rsp_perr},
                           {26'd0, e.hit, e.way, e.vic, e.perr});
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1;
      lk_val = 1'b0; lk_idx = '0; lk_tag = '0;
      wr_en = 1'b0; wr_inv = 1'b0; wr_idx = '0; wr_way = '0; wr_tag = '0;
      inv_all = 1'b0;

      // Reset state, then busy must last exactly SETS cycles
      @(negedge clk);
      chk("rst_rsp", {27'd0, rsp_val, rsp_hit, rsp_way, rsp_victim, rsp_perr} , 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd1);
      rst = 1'b0;
      n = 1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (busy) n++;
         else break;
      end
      chk("reset_busy_cycles", n, 64);

      // Empty directory: miss, lowest invalid way
      expect_rsp("lk_empty", 1'b0, 2'd0, 2'd0, 1'b0);
      look(6'd5, 22'h0);

      // Single fill then hit
      fill(6'd3, 2'd2, 22'h12345);
      expect_rsp("lk_hit_w2", 1'b1, 2'd2, 2'd0, 1'b0);
      look(6'd3, 22'h12345);
      fill(6'd3, 2'd0, 22'h000A0);
      fill(6'd3, 2'd1, 22'h000A1);
      fill(6'd3, 2'd3, 22'h000A3);

      // Full set 7: PLRU ordering
      for (int w = 0; w < 4; w++) fill(6'd7, WAY_W'(w), TAG_W'(32'h100 + w));
      expect_rsp("plru_hit_w0", 1'b1, 2'd0, 2'd0, 1'b0);
      look(6'd7, 22'h100);
      expect_rsp("plru_hit_w2", 1'b1, 2'd2, 2'd2, 1'b0);
      look(6'd7, 22'h102);
      expect_rsp("plru_vic_1", 1'b0, 2'd0, 2'd1, 1'b0);
      look(6'd7, 22'h3FF);
      fill(6'd7, 2'd1, 22'h101);
      expect_rsp("plru_vic_3", 1'b0, 2'd0, 2'd3, 1'b0);
      look(6'd7, 22'h3FF);

      // Same-cycle hit and fill on one set: the fill's MRU update wins
      expect_rsp("same_set_hit", 1'b1, 2'd0, 2'd3, 1'b0);
      cyc(1'b1, 6'd7, 22'h100, 1'b1, 1'b0, 6'd7, 2'd3, 22'h103, 1'b0);
      expect_rsp("write_plru_wins", 1'b0, 2'd0, 2'd0, 1'b0);
      look(6'd7, 22'h3FF);

      // Invalidate with a same-cycle lookup sees the old contents
      expect_rsp("inv_same_cycle_hit", 1'b1, 2'd2, 2'd0, 1'b0);
      cyc(1'b1, 6'd3, 22'h12345, 1'b1, 1'b1, 6'd3, 2'd2, 22'h0, 1'b0);
      expect_rsp("after_inv_miss", 1'b0, 2'd0, 2'd2, 1'b0);
      look(6'd3, 22'h12345);

      // Flash invalidate, restarted at cnt 40; lookups/writes while busy are dropped
      cyc(1'b0, '0, '0, 1'b1, 1'b0, 6'd10, 2'd0, 22'h55, 1'b1);
      for (int i = 0; i < 40; i++) @(negedge clk);
      chk("sweep_busy_mid", {31'd0, busy}, 32'd1);
      cyc(1'b1, 6'd7, 22'h100, 1'b0, 1'b0, '0, '0, '0, 1'b1);
      chk("busy_drop", {31'd0, rsp_val}, 32'd0);
      chk("busy_rdy", {31'd0, lk_rdy}, 32'd0);
      n = 1;
      for (int i = 0; i < 300; i++) begin
         if (n == 12) begin
            wr_en = 1'b1; wr_inv = 1'b0; wr_idx = 6'd2; wr_way = 2'd0; wr_tag = 22'h77;
         end else begin
            wr_en = 1'b0;
         end
         @(negedge clk);
         if (busy) n++;
         else break;
      end
      wr_en = 1'b0;
      chk("restart_busy_cycles", n, 64);
      expect_rsp("swept_miss", 1'b0, 2'd0, 2'd0, 1'b0);
      look(6'd7, 22'h100);
      expect_rsp("busy_write_ignored", 1'b0, 2'd0, 2'd0, 1'b0);
      look(6'd2, 22'h77);

`ifdef ICDIR_PARITY_EN
      // Corrupted parity on a holding way forces a miss and picks it as victim
      fill(6'd9, 2'd1, 22'h2AB);
      dut.par_q[9][1] = ~dut.par_q[9][1];
      expect_rsp("parity_err", 1'b0, 2'd0, 2'd1, 1'b1);
      look(6'd9, 22'h2AB);
`endif

      for (int i = 0; i < 4; i++) @(negedge clk);
      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
